// File: rtl/exe_if.sv
// Port bundle of the execute stage: ID/EX inputs, forwarding values, CPSR view,
// branch resolution and the EXE/MEM register outputs.
interface exe_if #(
    parameter int LEN_ADDRESS         = 32,
    parameter int LEN_REGISTER        = 32,
    parameter int LEN_STATUS          = 4,
    parameter int LEN_EXECUTE_COMMAND = 4,
    parameter int LEN_REG_ADDRESS     = 4
);
    logic                           freeze;
    logic [LEN_ADDRESS-1:0]         pc_in;
    logic [LEN_REGISTER-1:0]        reg_file_out1_in;
    logic [LEN_REGISTER-1:0]        reg_file_out2_in;
    logic [23:0]                    signed_immediate_in;
    logic [11:0]                    shift_operand_in;
    logic                           is_immediate_in;
    logic                           status_write_enable_in;
    logic                           mem_read_in;
    logic                           mem_write_in;
    logic                           wb_enable_in;
    logic                           is_branch_in;
    logic [LEN_EXECUTE_COMMAND-1:0] execute_command_in;
    logic [LEN_REG_ADDRESS-1:0]     dest_reg_in;
    logic [1:0]                     sel_src1;
    logic [1:0]                     sel_src2;
    logic [LEN_REGISTER-1:0]        mem_fwd_value;
    logic [LEN_REGISTER-1:0]        wb_fwd_value;

    logic [LEN_STATUS-1:0]          status_out;
    logic                           branch_taken;
    logic [LEN_ADDRESS-1:0]         branch_address;
    logic [LEN_REGISTER-1:0]        alu_result_out;
    logic [LEN_REGISTER-1:0]        st_val_out;
    logic [LEN_REG_ADDRESS-1:0]     dest_reg_out;
    logic                           wb_enable_out;
    logic                           mem_read_out;
    logic                           mem_write_out;

    modport master (
        output freeze, pc_in, reg_file_out1_in, reg_file_out2_in, signed_immediate_in,
               shift_operand_in, is_immediate_in, status_write_enable_in, mem_read_in,
               mem_write_in, wb_enable_in, is_branch_in, execute_command_in, dest_reg_in,
               sel_src1, sel_src2, mem_fwd_value, wb_fwd_value,
        input  status_out, branch_taken, branch_address, alu_result_out, st_val_out,
               dest_reg_out, wb_enable_out, mem_read_out, mem_write_out
    );

    modport slave (
        input  freeze, pc_in, reg_file_out1_in, reg_file_out2_in, signed_immediate_in,
               shift_operand_in, is_immediate_in, status_write_enable_in, mem_read_in,
               mem_write_in, wb_enable_in, is_branch_in, execute_command_in, dest_reg_in,
               sel_src1, sel_src2, mem_fwd_value, wb_fwd_value,
        output status_out, branch_taken, branch_address, alu_result_out, st_val_out,
               dest_reg_out, wb_enable_out, mem_read_out, mem_write_out
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, operand-2 shifter, ALU, CPSR and the EXE/MEM register.
// Branch target and branch_taken are resolved combinationally in the same cycle.
module exe_stage #(
    parameter int LEN_ADDRESS         = 32,
    parameter int LEN_REGISTER        = 32,
    parameter int LEN_STATUS          = 4,
    parameter int LEN_EXECUTE_COMMAND = 4,
    parameter int LEN_REG_ADDRESS     = 4
) (
    input logic  clk,
    input logic  rst,
    exe_if.slave bus
);
    localparam logic [LEN_EXECUTE_COMMAND-1:0] CMD_MOV = LEN_EXECUTE_COMMAND'(4'b0001);
    localparam logic [LEN_EXECUTE_COMMAND-1:0] CMD_MVN = LEN_EXECUTE_COMMAND'(4'b1001);
    localparam logic [LEN_EXECUTE_COMMAND-1:0] CMD_ADD = LEN_EXECUTE_COMMAND'(4'b0010);
    localparam logic [LEN_EXECUTE_COMMAND-1:0] CMD_ADC = LEN_EXECUTE_COMMAND'(4'b0011);
    localparam logic [LEN_EXECUTE_COMMAND-1:0] CMD_SUB = LEN_EXECUTE_COMMAND'(4'b0100);
    localparam logic [LEN_EXECUTE_COMMAND-1:0] CMD_SBC = LEN_EXECUTE_COMMAND'(4'b0101);
    localparam logic [LEN_EXECUTE_COMMAND-1:0] CMD_AND = LEN_EXECUTE_COMMAND'(4'b0110);
    localparam logic [LEN_EXECUTE_COMMAND-1:0] CMD_ORR = LEN_EXECUTE_COMMAND'(4'b0111);
    localparam logic [LEN_EXECUTE_COMMAND-1:0] CMD_EOR = LEN_EXECUTE_COMMAND'(4'b1000);

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_t;

    logic [LEN_REGISTER-1:0]    op_a;
    logic [LEN_REGISTER-1:0]    op_rm;
    logic [LEN_REGISTER-1:0]    val2;
    logic [LEN_REGISTER-1:0]    immediate;
    logic [LEN_REGISTER-1:0]    alu_result;
    logic [LEN_REGISTER:0]      sum;
    logic [4:0]                 rot_amount;
    logic [4:0]                 shift_amount;
    logic                       carry_in;
    logic                       is_add;
    logic                       is_sub;
    logic                       flags_valid;
    logic                       carry;
    logic                       overflow;
    logic [LEN_STATUS-1:0]      alu_status;
    logic [LEN_STATUS-1:0]      cpsr;
    logic [LEN_REGISTER-1:0]    alu_result_q;
    logic [LEN_REGISTER-1:0]    st_val_q;
    logic [LEN_REG_ADDRESS-1:0] dest_reg_q;
    logic                       wb_enable_q;
    logic                       mem_read_q;
    logic                       mem_write_q;

    function automatic logic [LEN_REGISTER-1:0] rotate_right(
        input logic [LEN_REGISTER-1:0] value,
        input logic [4:0]              amount
    );
        // A left shift by the full width yields zero, so amount 0 needs no special case.
        return (value >> amount) | (value << (LEN_REGISTER - int'(amount)));
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        op_a  = bus.reg_file_out1_in;
        op_rm = bus.reg_file_out2_in;
        case (bus.sel_src1)
            2'b01:   op_a = bus.mem_fwd_value;
            2'b10:   op_a = bus.wb_fwd_value;
            default: op_a = bus.reg_file_out1_in;
        endcase
        case (bus.sel_src2)
            2'b01:   op_rm = bus.mem_fwd_value;
            2'b10:   op_rm = bus.wb_fwd_value;
            default: op_rm = bus.reg_file_out2_in;
        endcase
    end

    assign rot_amount   = {bus.shift_operand_in[11:8], 1'b0};
    assign shift_amount = bus.shift_operand_in[11:7];
    assign immediate    = {{(LEN_REGISTER-8){1'b0}}, bus.shift_operand_in[7:0]};

    always_comb begin
        val2 = op_rm;
        if (bus.is_immediate_in) begin
            val2 = rotate_right(immediate, rot_amount);
        end else if (bus.mem_read_in || bus.mem_write_in) begin
            val2 = {{(LEN_REGISTER-12){1'b0}}, bus.shift_operand_in};
        end else begin
            case (shift_t'(bus.shift_operand_in[6:5]))
                SHIFT_LSL: val2 = op_rm << shift_amount;
                SHIFT_LSR: val2 = op_rm >> shift_amount;
                SHIFT_ASR: val2 = $unsigned($signed(op_rm) >>> shift_amount);
                default:   val2 = rotate_right(op_rm, shift_amount);
            endcase
        end
    end

    // Subtraction is A + ~Val2 + cin so the carry out is directly the ARM not-borrow flag.
    always_comb begin
        alu_result  = '0;
        sum         = '0;
        carry_in    = 1'b0;
        is_add      = 1'b0;
        is_sub      = 1'b0;
        flags_valid = 1'b1;
        case (bus.execute_command_in)
            CMD_MOV: alu_result = val2;
            CMD_MVN: alu_result = ~val2;
            CMD_ADD, CMD_ADC: begin
                is_add     = 1'b1;
                carry_in   = (bus.execute_command_in == CMD_ADC) && cpsr[1];
                sum        = {1'b0, op_a} + {1'b0, val2} + {{LEN_REGISTER{1'b0}}, carry_in};
                alu_result = sum[LEN_REGISTER-1:0];
            end
            CMD_SUB, CMD_SBC: begin
                is_sub     = 1'b1;
                carry_in   = (bus.execute_command_in == CMD_SUB) || cpsr[1];
                sum        = {1'b0, op_a} + {1'b0, ~val2} + {{LEN_REGISTER{1'b0}}, carry_in};
                alu_result = sum[LEN_REGISTER-1:0];
            end
            CMD_AND: alu_result = op_a & val2;
            CMD_ORR: alu_result = op_a | val2;
            CMD_EOR: alu_result = op_a ^ val2;
            default: flags_valid = 1'b0;
        endcase
    end

    assign carry    = (is_add || is_sub) && sum[LEN_REGISTER];
    assign overflow = (is_add && (op_a[LEN_REGISTER-1] == val2[LEN_REGISTER-1]) &&
                                 (alu_result[LEN_REGISTER-1] != op_a[LEN_REGISTER-1])) ||
                      (is_sub && (op_a[LEN_REGISTER-1] != val2[LEN_REGISTER-1]) &&
                                 (alu_result[LEN_REGISTER-1] != op_a[LEN_REGISTER-1]));
    assign alu_status = flags_valid ? {alu_result[LEN_REGISTER-1], ~|alu_result, carry, overflow}
                                    : '0;

    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpsr <= '0;
        end else if (bus.status_write_enable_in && !bus.freeze) begin
            cpsr <= alu_status;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q <= '0;
            st_val_q     <= '0;
            dest_reg_q   <= '0;
            wb_enable_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else if (!bus.freeze) begin
            alu_result_q <= alu_result;
            st_val_q     <= op_rm;
            dest_reg_q   <= bus.dest_reg_in;
            wb_enable_q  <= bus.wb_enable_in;
            mem_read_q   <= bus.mem_read_in;
            mem_write_q  <= bus.mem_write_in;
        end
    end

    assign bus.status_out     = cpsr;
    assign bus.branch_taken   = bus.is_branch_in;
    assign bus.branch_address = bus.pc_in + {{(LEN_ADDRESS-26){bus.signed_immediate_in[23]}},
                                             bus.signed_immediate_in, 2'b00};
    assign bus.alu_result_out = alu_result_q;
    assign bus.st_val_out     = st_val_q;
    assign bus.dest_reg_out   = dest_reg_q;
    assign bus.wb_enable_out  = wb_enable_q;
    assign bus.mem_read_out   = mem_read_q;
    assign bus.mem_write_out  = mem_write_q;
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the execute stage.
module tb_exe_stage;
    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_alu, m_st;
    logic [3:0]  m_dest, m_cpsr;
    logic        m_wb, m_mr, m_mw;

    always #5 clk = ~clk;

    exe_if bus ();
    exe_stage dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                              input logic [31:0] mem, input logic [31:0] wb);
        if (sel == 2'b01) return mem;
        if (sel == 2'b10) return wb;
        return rf;
    endfunction

    // Shifts are applied one bit position at a time.
    function automatic logic [31:0] model_val2(input logic imm, input logic is_mem,
                                               input logic [11:0] so, input logic [31:0] rm);
        logic [31:0] x;
        int n;
        if (imm) begin
            x = {24'd0, so[7:0]};
            n = 2 * int'(so[11:8]);
            for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
            return x;
        end
        if (is_mem) return {20'd0, so};
        x = rm;
        n = int'(so[11:7]);
        for (int i = 0; i < n; i++) begin
            case (so[6:5])
                2'b00:   x = {x[30:0], 1'b0};
                2'b01:   x = {1'b0, x[31:1]};
                2'b10:   x = {x[31], x[31:1]};
                default: x = {x[0], x[31:1]};
            endcase
        end
        return x;
    endfunction

    // Carry and overflow from 64-bit unsigned and signed arithmetic.
    function automatic void model_alu(input logic [3:0] cmd, input logic [31:0] a,
                                      input logic [31:0] b, input logic cin,
                                      output logic [31:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, full, sfull, extra;
        logic c, v, valid;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = $signed(a);
        sb = $signed(b);
        c = 1'b0; v = 1'b0; valid = 1'b1; r = 32'd0;
        case (cmd)
            4'd1: r = b;
            4'd9: r = ~b;
            4'd2, 4'd3: begin
                extra = (cmd == 4'd3 && cin) ? 64'sd1 : 64'sd0;
                full  = ua + ub + extra;
                r     = full[31:0];
                c     = full >= 64'sd4294967296;
                sfull = sa + sb + extra;
                v     = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                extra = (cmd == 4'd5 && !cin) ? 64'sd1 : 64'sd0;
                full  = ua - ub - extra;
                r     = full[31:0];
                c     = ua >= ub + extra;
                sfull = sa - sb - extra;
                v     = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
            end
            4'd6: r = a & b;
            4'd7: r = a | b;
            4'd8: r = a ^ b;
            default: valid = 1'b0;
        endcase
        f = valid ? {r[31], r == 32'd0, c, v} : 4'd0;
    endfunction

    task automatic set_idle();
        bus.freeze = 0; bus.pc_in = 0; bus.reg_file_out1_in = 0; bus.reg_file_out2_in = 0;
        bus.signed_immediate_in = 0; bus.shift_operand_in = 0; bus.is_immediate_in = 0;
        bus.status_write_enable_in = 0; bus.mem_read_in = 0; bus.mem_write_in = 0;
        bus.wb_enable_in = 0; bus.is_branch_in = 0; bus.execute_command_in = 0;
        bus.dest_reg_in = 0; bus.sel_src1 = 0; bus.sel_src2 = 0;
        bus.mem_fwd_value = 0; bus.wb_fwd_value = 0;
    endtask

    task automatic clear_model();
        m_alu = 0; m_st = 0; m_dest = 0; m_cpsr = 0; m_wb = 0; m_mr = 0; m_mw = 0;
    endtask

    task automatic drive_op(input logic [3:0] cmd, input logic imm, input logic [11:0] so,
                            input logic s, input logic [31:0] a, input logic [31:0] rm);
        bus.execute_command_in = cmd; bus.is_immediate_in = imm; bus.shift_operand_in = so;
        bus.status_write_enable_in = s; bus.reg_file_out1_in = a; bus.reg_file_out2_in = rm;
    endtask

    // Advances one clock and updates the reference model with what the stage should latch.
    task automatic cycle();
        logic [31:0] a, rm, v2, r;
        logic [3:0]  f;
        a  = model_fwd(bus.sel_src1, bus.reg_file_out1_in, bus.mem_fwd_value, bus.wb_fwd_value);
        rm = model_fwd(bus.sel_src2, bus.reg_file_out2_in, bus.mem_fwd_value, bus.wb_fwd_value);
        v2 = model_val2(bus.is_immediate_in, bus.mem_read_in | bus.mem_write_in,
                        bus.shift_operand_in, rm);
        model_alu(bus.execute_command_in, a, v2, m_cpsr[1], r, f);
        @(posedge clk);
        if (!bus.freeze) begin
            m_alu = r; m_st = rm; m_dest = bus.dest_reg_in;
            m_wb = bus.wb_enable_in; m_mr = bus.mem_read_in; m_mw = bus.mem_write_in;
            if (bus.status_write_enable_in) m_cpsr = f;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.alu_result_out, bus.st_val_out, bus.dest_reg_out, bus.wb_enable_out,
             bus.mem_read_out, bus.mem_write_out} !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs: got alu=%h st=%h dest=%h, expected all zero",
                     bus.alu_result_out, bus.st_val_out, bus.dest_reg_out);
        end
        checks++;
        if (bus.status_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: got %b expected 0000", bus.status_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith_flags();
        set_idle();
        drive_op(OP_ADD, 1'b1, 12'h001, 1'b1, 32'hFFFF_FFFF, 32'd0);
        cycle();
        checks++;
        if (bus.alu_result_out !== 32'd0 || bus.status_out !== 4'b0110) begin
            errors++;
            $display("FAIL add_wrap: got %h/%b expected 00000000/0110",
                     bus.alu_result_out, bus.status_out);
        end
        drive_op(OP_SUB, 1'b1, 12'h001, 1'b1, 32'h8000_0000, 32'd0);
        cycle();
        checks++;
        if (bus.alu_result_out !== 32'h7FFF_FFFF || bus.status_out !== 4'b0011) begin
            errors++;
            $display("FAIL sub_overflow: got %h/%b expected 7fffffff/0011",
                     bus.alu_result_out, bus.status_out);
        end
        drive_op(4'b0000, 1'b1, 12'h005, 1'b1, 32'd7, 32'd0);
        cycle();
        checks++;
        if (bus.alu_result_out !== 32'd0 || bus.status_out !== 4'b0000) begin
            errors++;
            $display("FAIL invalid_opcode: got %h/%b expected 00000000/0000",
                     bus.alu_result_out, bus.status_out);
        end
    endtask

    task automatic test_shifter();
        logic [11:0] so_tab [5] = '{12'h4FF, 12'h0AB, 12'h240, 12'h060, 12'hABC};
        logic        imm_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        mem_tab[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp_tab[5] = '{32'hFF00_0000, 32'h0000_00AB, 32'hF800_0000,
                                    32'h8000_0000, 32'h0000_0ABC};
        set_idle();
        for (int i = 0; i < 5; i++) begin
            drive_op(OP_MOV, imm_tab[i], so_tab[i], 1'b0, 32'd0, 32'h8000_0000);
            bus.mem_read_in = mem_tab[i];
            cycle();
            checks++;
            if (bus.alu_result_out !== exp_tab[i] || bus.mem_read_out !== mem_tab[i]) begin
                errors++;
                $display("FAIL shifter_%0d: got %h mr=%b expected %h mr=%b", i,
                         bus.alu_result_out, bus.mem_read_out, exp_tab[i], mem_tab[i]);
            end
        end
    endtask

    task automatic test_branch();
        set_idle();
        bus.pc_in = 32'h100; bus.signed_immediate_in = 24'hFFFFFE; bus.is_branch_in = 1'b1;
        #1;
        checks++;
        if (bus.branch_taken !== 1'b1 || bus.branch_address !== 32'h0000_00F8) begin
            errors++;
            $display("FAIL branch_back: got %b/%h expected 1/000000f8",
                     bus.branch_taken, bus.branch_address);
        end
        bus.pc_in = 32'h1000; bus.signed_immediate_in = 24'h000010; bus.is_branch_in = 1'b0;
        #1;
        checks++;
        if (bus.branch_taken !== 1'b0 || bus.branch_address !== 32'h0000_1040) begin
            errors++;
            $display("FAIL branch_fwd: got %b/%h expected 0/00001040",
                     bus.branch_taken, bus.branch_address);
        end
        cycle();
    endtask

    task automatic test_forwarding();
        logic [1:0]  sel_tab[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [31:0] exp_a  [4] = '{32'd8, 32'h13, 32'h7A, 32'h7A};
        logic [31:0] exp_st [4] = '{32'd5, 32'h10, 32'h99, 32'h99};
        set_idle();
        bus.mem_fwd_value = 32'd5; bus.wb_fwd_value = 32'h10;
        for (int i = 0; i < 4; i++) begin
            drive_op(OP_ADD, 1'b1, 12'h003, 1'b0, 32'h77, 32'h99);
            bus.sel_src1 = sel_tab[i]; bus.sel_src2 = sel_tab[i];
            cycle();
            checks++;
            if (bus.alu_result_out !== exp_a[i] || bus.st_val_out !== exp_st[i]) begin
                errors++;
                $display("FAIL forward_sel%b: got alu=%h st=%h expected alu=%h st=%h",
                         sel_tab[i], bus.alu_result_out, bus.st_val_out, exp_a[i], exp_st[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_idle();
        drive_op(OP_ADD, 1'b1, 12'h001, 1'b1, 32'hFFFF_FFFF, 32'd0);
        cycle();
        drive_op(OP_ADC, 1'b1, 12'h001, 1'b0, 32'd1, 32'd0);
        cycle();
        checks++;
        if (bus.alu_result_out !== 32'd3) begin
            errors++;
            $display("FAIL adc_after_add: got %h expected 00000003", bus.alu_result_out);
        end
        drive_op(OP_SBC, 1'b1, 12'h002, 1'b1, 32'd5, 32'd0);
        cycle();
        checks++;
        if (bus.alu_result_out !== 32'd3 || bus.status_out !== 4'b0010) begin
            errors++;
            $display("FAIL sbc_carry_set: got %h/%b expected 00000003/0010",
                     bus.alu_result_out, bus.status_out);
        end
    endtask

    task automatic test_freeze();
        set_idle();
        drive_op(OP_MOV, 1'b1, 12'h055, 1'b1, 32'd0, 32'd0);
        bus.dest_reg_in = 4'd3; bus.wb_enable_in = 1'b1;
        cycle();
        bus.freeze = 1'b1;
        drive_op(OP_SUB, 1'b1, 12'h001, 1'b1, 32'd0, 32'hDEAD);
        bus.dest_reg_in = 4'd9; bus.wb_enable_in = 1'b0; bus.mem_write_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if ({bus.alu_result_out, bus.status_out, bus.dest_reg_out, bus.wb_enable_out,
                 bus.mem_write_out} !== {32'h55, 4'b0000, 4'd3, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL freeze_hold_%0d: got alu=%h st=%b dest=%h wb=%b mw=%b", i,
                         bus.alu_result_out, bus.status_out, bus.dest_reg_out,
                         bus.wb_enable_out, bus.mem_write_out);
            end
        end
        bus.freeze = 1'b0;
        cycle();
        checks++;
        if (bus.alu_result_out !== 32'hFFFF_FFFF || bus.status_out !== 4'b1000 ||
            bus.mem_write_out !== 1'b1) begin
            errors++;
            $display("FAIL freeze_release: got %h/%b mw=%b expected ffffffff/1000 mw=1",
                     bus.alu_result_out, bus.status_out, bus.mem_write_out);
        end
    endtask

    task automatic test_random();
        logic [74:0] act, exp;
        logic [31:0] exp_ba;
        logic [31:0] corner[4] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        set_idle();
        for (int i = 0; i < 400; i++) begin
            bus.freeze = ($urandom_range(0, 7) == 0);
            bus.pc_in = $urandom(); bus.signed_immediate_in = 24'($urandom());
            bus.is_branch_in = 1'($urandom());
            bus.reg_file_out1_in = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)]
                                                              : $urandom();
            bus.reg_file_out2_in = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)]
                                                              : $urandom();
            bus.shift_operand_in = 12'($urandom());
            bus.is_immediate_in = ($urandom_range(0, 2) == 0);
            bus.mem_read_in = ($urandom_range(0, 4) == 0);
            bus.mem_write_in = ($urandom_range(0, 4) == 0);
            bus.wb_enable_in = 1'($urandom());
            bus.status_write_enable_in = 1'($urandom());
            bus.execute_command_in = 4'($urandom());
            bus.dest_reg_in = 4'($urandom());
            bus.sel_src1 = 2'($urandom()); bus.sel_src2 = 2'($urandom());
            bus.mem_fwd_value = $urandom(); bus.wb_fwd_value = $urandom();
            #1;
            exp_ba = bus.pc_in + 32'(4 * int'($signed(bus.signed_immediate_in)));
            checks++;
            if (bus.branch_address !== exp_ba || bus.branch_taken !== bus.is_branch_in) begin
                errors++;
                $display("FAIL rand_branch_%0d: got %b/%h expected %b/%h", i,
                         bus.branch_taken, bus.branch_address, bus.is_branch_in, exp_ba);
            end
            cycle();
            act = {bus.alu_result_out, bus.st_val_out, bus.dest_reg_out, bus.wb_enable_out,
                   bus.mem_read_out, bus.mem_write_out, bus.status_out};
            exp = {m_alu, m_st, m_dest, m_wb, m_mr, m_mw, m_cpsr};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL rand_exec_%0d: got alu=%h st=%h dest=%h ctl=%b nzcv=%b expected alu=%h st=%h dest=%h ctl=%b nzcv=%b",
                         i, act[74:43], act[42:11], act[10:7], act[6:4], act[3:0],
                         exp[74:43], exp[42:11], exp[10:7], exp[6:4], exp[3:0]);
            end
        end
        bus.freeze = 1'b0;
    endtask

    task automatic test_async_reset();
        set_idle();
        drive_op(OP_SUB, 1'b1, 12'h001, 1'b1, 32'd0, 32'h1234);
        bus.dest_reg_in = 4'hF; bus.wb_enable_in = 1'b1; bus.mem_write_in = 1'b1;
        cycle();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.alu_result_out, bus.st_val_out, bus.dest_reg_out, bus.wb_enable_out,
             bus.mem_read_out, bus.mem_write_out, bus.status_out} !== 75'd0) begin
            errors++;
            $display("FAIL async_reset: got alu=%h st=%h dest=%h nzcv=%b expected all zero",
                     bus.alu_result_out, bus.st_val_out, bus.dest_reg_out, bus.status_out);
        end
        clear_model();
        #1;
        rst = 1'b0;
        drive_op(OP_ADD, 1'b1, 12'h002, 1'b1, 32'd40, 32'd0);
        cycle();
        checks++;
        if (bus.alu_result_out !== m_alu || bus.status_out !== m_cpsr) begin
            errors++;
            $display("FAIL after_reset: got %h/%b expected %h/%b",
                     bus.alu_result_out, bus.status_out, m_alu, m_cpsr);
        end
    endtask

    initial begin
        test_reset();
        test_arith_flags();
        test_shifter();
        test_branch();
        test_forwarding();
        test_back_to_back();
        test_freeze();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
